// File: rtl/ct_ifu_btb_tag_array_ctrl.sv
// BTB tag array with invalidation sweep, one-entry write buffer,
// read bypass of the buffered write and per-way write masking.

module gated_clk_cell (
   input  logic clk_in,
   input  logic global_en,
   input  logic module_en,
   input  logic local_en,
   input  logic external_en,
   input  logic pad_yy_icg_scan_en,
   output logic clk_out
);
   logic en_bf;
   logic en_lat;

   assign en_bf = (global_en & (module_en | local_en)) | external_en;

   // Latch is transparent while the clock is low so clk_out never glitches
   always_latch begin
      if (!clk_in) en_lat = en_bf;
   end

   assign clk_out = clk_in & (en_lat | pad_yy_icg_scan_en);
endmodule

module ct_ifu_btb_tag_array_ctrl #(
   parameter int INDEX_W = 9,
   parameter int TAG_W   = 11,
   parameter int WAYS    = 4
) (
   input  logic                    forever_cpuclk,
   input  logic                    cpurst_b,
   input  logic                    cp0_yy_clk_en,
   input  logic                    cp0_ifu_icg_en,
   input  logic                    pad_yy_icg_scan_en,
   input  logic                    inv_all,
   input  logic                    rd_vld,
   input  logic [INDEX_W-1:0]      rd_index,
   output logic                    rd_rdy,
   input  logic                    wr_vld,
   input  logic [INDEX_W-1:0]      wr_index,
   input  logic [WAYS-1:0]         wr_way_mask,
   input  logic [TAG_W-1:0]        wr_tag,
   output logic                    wr_rdy,
   output logic [WAYS*TAG_W-1:0]   rd_dout,
   output logic                    rd_dout_vld,
   output logic                    init_busy
);
   localparam int DEPTH = 1 << INDEX_W;
   localparam int DW    = WAYS * TAG_W;

   typedef enum logic {INIT, RUN} state_e;

   state_e             state_q, state_d;
   logic [INDEX_W-1:0] cnt_q, cnt_d;

   logic               buf_vld_q, buf_vld_d;
   logic [INDEX_W-1:0] buf_index_q, buf_index_d;
   logic [WAYS-1:0]    buf_mask_q, buf_mask_d;
   logic [TAG_W-1:0]   buf_tag_q, buf_tag_d;

   logic [DW-1:0]      rd_dout_q, rd_dout_d;
   logic               rd_dout_vld_q, rd_dout_vld_d;

   logic               run_ok;
   logic               rd_acc;
   logic               wr_acc;
   logic               mem_we;
   logic [INDEX_W-1:0] mem_idx;
   logic [WAYS-1:0]    mem_mask;
   logic [TAG_W-1:0]   mem_tag;
   logic               mem_clk;
   logic               mem_clk_en;
   logic [DW-1:0]      rd_raw;
   logic [DW-1:0]      rd_merged;

   logic [DW-1:0]      mem [DEPTH];

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         INIT: begin
            if (inv_all) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == {INDEX_W{1'b1}}) state_d = RUN;
            end
         end
         RUN: begin
            if (inv_all) begin
               state_d = INIT;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = INIT;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      init_busy = (state_q == INIT);
      rd_rdy    = !init_busy;
      run_ok    = !init_busy & !inv_all;
      wr_rdy    = run_ok & (!rd_vld | !buf_vld_q);
      rd_acc    = run_ok & rd_vld;
      wr_acc    = wr_vld & wr_rdy;
      mem_we    = 1'b0;
      mem_idx   = cnt_q;
      mem_mask  = '0;
      mem_tag   = '0;
      if (init_busy) begin
         mem_we   = 1'b1;
         mem_idx  = cnt_q;
         mem_mask = '1;
      end else if (run_ok && !rd_vld) begin
         if (buf_vld_q) begin
            mem_we   = 1'b1;
            mem_idx  = buf_index_q;
            mem_mask = buf_mask_q;
            mem_tag  = buf_tag_q;
         end else if (wr_vld) begin
            mem_we   = 1'b1;
            mem_idx  = wr_index;
            mem_mask = wr_way_mask;
            mem_tag  = wr_tag;
         end
      end
   end

   // A write is buffered only when a read owns the port or the buffer drains
   always_comb begin
      buf_vld_d   = buf_vld_q;
      buf_index_d = buf_index_q;
      buf_mask_d  = buf_mask_q;
      buf_tag_d   = buf_tag_q;
      if (!run_ok) begin
         buf_vld_d = 1'b0;
      end else if (wr_acc && (rd_vld || buf_vld_q)) begin
         buf_vld_d   = 1'b1;
         buf_index_d = wr_index;
         buf_mask_d  = wr_way_mask;
         buf_tag_d   = wr_tag;
      end else if (!rd_vld) begin
         buf_vld_d = 1'b0;
      end
   end

   always_comb begin
      rd_raw    = mem[rd_index];
      rd_merged = rd_raw;
      for (int i = 0; i < WAYS; i++) begin
         if (buf_vld_q && (buf_index_q == rd_index) && buf_mask_q[i])
            rd_merged[i*TAG_W +: TAG_W] = buf_tag_q;
      end
      rd_dout_d     = rd_acc ? rd_merged : rd_dout_q;
      rd_dout_vld_d = rd_acc;
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         buf_vld_q     <= 1'b0;
         buf_index_q   <= '0;
         buf_mask_q    <= '0;
         buf_tag_q     <= '0;
         rd_dout_q     <= '0;
         rd_dout_vld_q <= 1'b0;
      end else begin
         buf_vld_q     <= buf_vld_d;
         buf_index_q   <= buf_index_d;
         buf_mask_q    <= buf_mask_d;
         buf_tag_q     <= buf_tag_d;
         rd_dout_q     <= rd_dout_d;
         rd_dout_vld_q <= rd_dout_vld_d;
      end
   end

   assign rd_dout     = rd_dout_q;
   assign rd_dout_vld = rd_dout_vld_q;

   assign mem_clk_en = init_busy | (rd_vld & rd_rdy) | buf_vld_q | wr_vld;

   gated_clk_cell u_mem_icg (
      .clk_in             (forever_cpuclk),
      .global_en          (cp0_yy_clk_en),
      .module_en          (cp0_ifu_icg_en),
      .local_en           (mem_clk_en),
      .external_en        (1'b0),
      .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
      .clk_out            (mem_clk)
   );

   always_ff @(posedge mem_clk) begin
      for (int i = 0; i < WAYS; i++) begin
         if (mem_we && mem_mask[i])
            mem[mem_idx][i*TAG_W +: TAG_W] <= mem_tag;
      end
   end
endmodule

// File: tb/tb_ct_ifu_btb_tag_array_ctrl.sv
// Directed bench for the BTB tag array: read results are checked
// against a queue of expected words filled as reads are issued.

module tb_ct_ifu_btb_tag_array_ctrl;
   localparam int IW = 9;
   localparam int TW = 11;
   localparam int NW = 4;
   localparam int DW = NW * TW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clk_en, icg_en, scan_en;
   logic          inv_all;
   logic          rd_vld;
   logic [IW-1:0] rd_index;
   logic          rd_rdy;
   logic          wr_vld;
   logic [IW-1:0] wr_index;
   logic [NW-1:0] wr_way_mask;
   logic [TW-1:0] wr_tag;
   logic          wr_rdy;
   logic [DW-1:0] rd_dout;
   logic          rd_dout_vld;
   logic          init_busy;

   int errs = 0;
   int checks = 0;
   logic [DW-1:0] sb[$];
   logic [DW-1:0] last_exp;

   always #5 clk = ~clk;

   ct_ifu_btb_tag_array_ctrl #(.INDEX_W(IW), .TAG_W(TW), .WAYS(NW)) dut (
      .forever_cpuclk     (clk),
      .cpurst_b           (rst_n),
      .cp0_yy_clk_en      (clk_en),
      .cp0_ifu_icg_en     (icg_en),
      .pad_yy_icg_scan_en (scan_en),
      .inv_all            (inv_all),
      .rd_vld             (rd_vld),
      .rd_index           (rd_index),
      .rd_rdy             (rd_rdy),
      .wr_vld             (wr_vld),
      .wr_index           (wr_index),
      .wr_way_mask        (wr_way_mask),
      .wr_tag             (wr_tag),
      .wr_rdy             (wr_rdy),
      .rd_dout            (rd_dout),
      .rd_dout_vld        (rd_dout_vld),
      .init_busy          (init_busy)
   );

   function automatic logic [DW-1:0] pack(input logic [TW-1:0] w3, w2, w1, w0);
      return {w3, w2, w1, w0};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [IW-1:0] idx, input logic [DW-1:0] exp);
      rd_vld   = 1'b1;
      rd_index = idx;
      sb.push_back(exp);
      step();
      rd_vld = 1'b0;
   endtask

   task automatic sweep_len(input string tag);
      int n;
      logic bad;
      n = 0;
      bad = 1'b0;
      while (init_busy && n < 600) begin
         if (rd_rdy !== 1'b0 || wr_rdy !== 1'b0) bad = 1'b1;
         rd_vld = (n < 100);
         rd_index = 9'd5;
         step();
         n++;
      end
      rd_vld = 1'b0;
      chk({tag, "_len"}, n, 512);
      chk({tag, "_rdy_low"}, bad, 0);
      chk({tag, "_rd_rdy_up"}, rd_rdy, 1);
   endtask

   always @(negedge clk) begin
      if (rst_n && rd_dout_vld) begin
         if (sb.size() == 0) begin
            chk("unexpected_rd_dout_vld", 1, 0);
         end else begin
            last_exp = sb.pop_front();
            chk("rd_dout", rd_dout, last_exp);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      clk_en = 1'b1;
      icg_en = 1'b0;
      scan_en = 1'b0;
      inv_all = 1'b0;
      rd_vld = 1'b0;
      rd_index = '0;
      wr_vld = 1'b0;
      wr_index = '0;
      wr_way_mask = '0;
      wr_tag = '0;
      #3;
      chk("rst_init_busy", init_busy, 1);
      chk("rst_rd_rdy", rd_rdy, 0);
      chk("rst_wr_rdy", wr_rdy, 0);
      chk("rst_rd_dout_vld", rd_dout_vld, 0);
      chk("rst_rd_dout", rd_dout, 0);
      step();
      step();
      rst_n = 1'b1;
      sweep_len("sweep0");

      rd(9'd0, '0);
      rd(9'd255, '0);
      rd(9'd511, '0);

      // direct write then read next cycle
      wr_vld = 1'b1;
      wr_index = 9'd5;
      wr_way_mask = 4'b0101;
      wr_tag = 11'h3A5;
      #1 chk("direct_wr_rdy", wr_rdy, 1);
      step();
      wr_vld = 1'b0;
      rd(9'd5, pack(11'h0, 11'h3A5, 11'h0, 11'h3A5));
      step();
      step();
      chk("rd_dout_hold", rd_dout, pack(11'h0, 11'h3A5, 11'h0, 11'h3A5));

      // same-cycle read and write to set 7
      rd_vld = 1'b1;
      rd_index = 9'd7;
      wr_vld = 1'b1;
      wr_index = 9'd7;
      wr_way_mask = 4'b1111;
      wr_tag = 11'h111;
      sb.push_back('0);
      #1 chk("rw7_wr_rdy", wr_rdy, 1);
      step();
      wr_vld = 1'b0;
      rd(9'd7, pack(11'h111, 11'h111, 11'h111, 11'h111));
      step();
      rd(9'd7, pack(11'h111, 11'h111, 11'h111, 11'h111));

      // partial-mask bypass merges with storage
      rd_vld = 1'b1;
      rd_index = 9'd5;
      wr_vld = 1'b1;
      wr_index = 9'd5;
      wr_way_mask = 4'b1000;
      wr_tag = 11'h7FF;
      sb.push_back(pack(11'h0, 11'h3A5, 11'h0, 11'h3A5));
      step();
      wr_vld = 1'b0;
      rd(9'd5, pack(11'h7FF, 11'h3A5, 11'h0, 11'h3A5));
      step();

      // continuous reads with a full buffer
      rd_vld = 1'b1;
      rd_index = 9'd20;
      wr_vld = 1'b1;
      wr_index = 9'd20;
      wr_way_mask = 4'b0001;
      wr_tag = 11'h0AA;
      sb.push_back('0);
      #1 chk("cont_a_wr_rdy", wr_rdy, 1);
      step();
      rd_index = 9'd21;
      wr_index = 9'd21;
      wr_way_mask = 4'b0010;
      wr_tag = 11'h0BB;
      sb.push_back('0);
      #1 chk("cont_b_wr_rdy", wr_rdy, 0);
      step();
      rd_index = 9'd20;
      sb.push_back(pack(11'h0, 11'h0, 11'h0, 11'h0AA));
      #1 chk("cont_c_wr_rdy", wr_rdy, 0);
      step();
      rd_vld = 1'b0;
      #1 chk("cont_d_wr_rdy", wr_rdy, 1);
      step();
      wr_vld = 1'b0;
      rd(9'd21, pack(11'h0, 11'h0, 11'h0BB, 11'h0));
      step();
      rd(9'd20, pack(11'h0, 11'h0, 11'h0, 11'h0AA));
      rd(9'd21, pack(11'h0, 11'h0, 11'h0BB, 11'h0));

      // zero mask write is accepted but changes nothing
      wr_vld = 1'b1;
      wr_index = 9'd20;
      wr_way_mask = 4'b0000;
      wr_tag = 11'h7FF;
      #1 chk("mask0_wr_rdy", wr_rdy, 1);
      step();
      wr_vld = 1'b0;
      rd(9'd20, pack(11'h0, 11'h0, 11'h0, 11'h0AA));

      // inv_all with a buffered write to set 9
      rd_vld = 1'b1;
      rd_index = 9'd9;
      wr_vld = 1'b1;
      wr_index = 9'd9;
      wr_way_mask = 4'b1111;
      wr_tag = 11'h123;
      sb.push_back('0);
      #1 chk("inv_pre_wr_rdy", wr_rdy, 1);
      step();
      inv_all = 1'b1;
      rd_index = 9'd9;
      wr_index = 9'd10;
      wr_tag = 11'h555;
      #1 chk("inv_wr_rdy", wr_rdy, 0);
      step();
      inv_all = 1'b0;
      rd_vld = 1'b0;
      wr_vld = 1'b0;
      chk("inv_busy_next", init_busy, 1);
      sweep_len("sweep_inv");
      rd(9'd9, '0);
      rd(9'd10, '0);
      rd(9'd20, '0);

      // reset in the middle of a sweep restarts it
      wr_vld = 1'b1;
      wr_index = 9'd30;
      wr_way_mask = 4'b1111;
      wr_tag = 11'h2C3;
      step();
      wr_vld = 1'b0;
      inv_all = 1'b1;
      step();
      inv_all = 1'b0;
      repeat (300) step();
      rst_n = 1'b0;
      #2 chk("mid_rst_busy", init_busy, 1);
      step();
      rst_n = 1'b1;
      sweep_len("sweep_rst");
      rd(9'd30, '0);
      rd(9'd0, '0);

      step();
      step();
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/ct_ifu_btb_tag_array_ctrl.md
# ct_ifu_btb_tag_array_ctrl

Parametrised BTB tag storage with integrated access control for the IFU branch predictor. It holds WAYS tags per set, each TAG_W bits, across 2^INDEX_W sets, with one storage access per cycle. Beyond plain storage, it adds:
- a power-on / flush invalidation sweep;
- a one-entry write buffer so reads always win the port;
- read-after-buffered-write bypass;
- per-way write masking.

It sits between the BTB lookup/update logic and the tag RAM. It replaces fixed-size banked tag-array wrappers.

## Interface
- INDEX_W, 9, set index width; DEPTH = 2^INDEX_W sets
- TAG_W, 11, tag width per way; all-zero tag = invalid entry
- WAYS, 4, ways per set
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  asynchronous active-low reset
- cp0_yy_clk_en  in  1  global clock-gate enable
- cp0_ifu_icg_en  in  1  module clock-gate enable
- pad_yy_icg_scan_en  in  1  scan clock-gate override
- inv_all  in  1  pulse: invalidate whole array
- rd_vld  in  1  read request
- rd_index  in  INDEX_W  read set
- rd_rdy  out  1  read accepted (= !init_busy)
- wr_vld  in  1  write request
- wr_index  in  INDEX_W  write set
- wr_way_mask  in  WAYS  ways to write, bit i = way i
- wr_tag  in  TAG_W  tag written to every masked way
- wr_rdy  out  1  write accepted this cycle
- rd_dout  out  WAYS*TAG_W  way i at bits [i*TAG_W +: TAG_W]
- rd_dout_vld  out  1  rd_dout updated this cycle
- init_busy  out  1  invalidation sweep in progress

## Operation
- Storage is an internal DEPTH x (WAYS*TAG_W) array with per-way write enables.
- The storage is clocked through a gated_clk_cell:
  - clk_in = forever_cpuclk, external_en = 0;
  - local_en = init_busy | (rd_vld & rd_rdy) | buf_vld | wr_vld.
- All control and output registers run on ungated forever_cpuclk.
- FSM states: INIT, RUN.
  - Reset enters INIT with sweep counter 0.
  - INIT: each cycle writes zero to all ways of set[counter], then counter increments. After set DEPTH-1 is written, go to RUN.
  - inv_all in RUN: go to INIT, counter = 0, write buffer discarded.
  - inv_all in INIT: counter restarts at 0.
- In INIT: rd_rdy = 0, wr_rdy = 0. rd_vld and wr_vld are ignored (no buffer load, no rd_dout_vld).
- Port arbitration in RUN, evaluated in this order each cycle:
  1. rd_vld: the read uses the port. wr_rdy = !buf_vld. An accepted write loads the buffer.
  2. else buf_vld: the buffer drains to storage. wr_rdy = 1. An accepted write reloads the buffer in the same cycle (buf_vld stays 1).
  3. else wr_vld: write goes directly to storage. wr_rdy = 1. The buffer stays empty.
- Write semantics:
  - Only ways with wr_way_mask[i] = 1 change.
  - A write with wr_way_mask = 0 is accepted and has no effect.
- Read bypass:
  - When a read is issued with buf_vld = 1 and rd_index == buf_index, the masked ways of the returned data are replaced by buf_tag.
  - The other ways come from storage.
- Same-cycle read and write to the same set: the read returns pre-write contents. The write is only buffered that cycle, so there is no bypass.
- inv_all takes effect in the same cycle it is sampled:
  - a read issued in that cycle is not accepted;
  - a write presented in that cycle is not accepted.

## Timing
- Reset values:
  - state INIT, counter 0, init_busy 1;
  - rd_rdy 0, wr_rdy 0;
  - rd_dout_vld 0, rd_dout all zero;
  - buffer empty.
- Sweep takes exactly DEPTH cycles. With default INDEX_W = 9, init_busy is high for 512 cycles after cpurst_b rises, then drops; rd_rdy rises in the same cycle.
- Read latency is 1: a read accepted in cycle N gives rd_dout_vld = 1 and valid rd_dout in cycle N+1.
- rd_dout holds its value until the next accepted read. rd_dout_vld is a one-cycle pulse per read.
- A directly written tag is visible to a read issued in the next cycle.
- A buffered tag is visible via bypass from the cycle after buffer load, until it drains.
- Buffer drain occurs in the first cycle without rd_vld. With continuous reads, the buffer holds and wr_rdy stays 0.
- Reset asserted mid-sweep or mid-operation restarts the sweep from set 0. Buffer contents are lost.

## Test plan
- Reset release:
  - init_busy high exactly 512 cycles, rd_rdy low throughout;
  - then a read of sets 0, 255, 511 returns rd_dout = 0 one cycle later.
- Direct write: set 5, mask 4'b0101, tag 11'h3A5; next cycle read set 5 -> rd_dout way0 = way2 = 11'h3A5, way1 = way3 = 0.
- Same-cycle read + write to set 7 (tag 11'h111, mask 4'b1111):
  - read returns zeros; wr_rdy = 1;
  - read of set 7 next cycle returns 11'h111 on all ways (bypass);
  - after one idle cycle, storage holds 11'h111.
- Continuous reads with buffer full: second wr_vld sees wr_rdy = 0 until the first read-free cycle; then the buffer drains and the new write loads in the same cycle.
- inv_all with buffered write to set 9:
  - init_busy rises next cycle for 512 cycles;
  - afterwards a read of set 9 returns 0 (buffer discarded).
- Reset asserted at sweep set 300: after release, init_busy stays high a full 512 cycles.
